dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Memory-side responder for the CPU data-memory interface.
- Accepts word-aligned requests carrying 4-bit byte-lane write enables and lane-replicated store data, as produced by the core's load/store controller.
- Returns the full 32-bit word; the core extracts and sign-extends bytes and halfwords itself.
- Adds a req/ack handshake with configurable wait states, so the pipeline can be exercised against slow memory.

Parameters:
- DEPTH_WORDS, 1024: memory depth in 32-bit words; must be a power of two.
- ADDR_W, $clog2(DEPTH_WORDS): word-index width, derived; never overridden.
- WAIT_CYCLES, 0: extra wait states per access. Legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  request valid; sampled only while busy=0.
- we  in  4  byte-lane write enables, lane i = wdata[8i+7:8i]; all zero means a read.
- addr  in  32  byte address. Bits [1:0] are ignored; bits [ADDR_W+1:2] give the word index.
- wdata  in  32  store data, already lane-replicated.
- rdata  out  32  read word; valid when ack=1, held until the next ack.
- ack  out  1  one-cycle response pulse.
- busy  out  1  high while an accepted request is in wait states.
- err  out  1  out-of-range flag; pulses with ack (see Optional Feature).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cnt=0, ack=0, busy=0, err=0, rdata=0. Memory contents are not reset; they are zero-initialised at elaboration. A request that is pending when reset asserts is discarded, and its write never reaches memory.
- FSM states are IDLE and WAIT. busy = (state==WAIT).
- A request is accepted at a rising edge where req=1 and busy=0. Accepting latches addr, we and wdata.
- If WAIT_CYCLES=0:
  - The access is performed at the accept edge.
  - ack=1 in the following cycle, i.e. one cycle of latency.
  - A new request may be accepted at every edge, giving throughput of one per cycle.
- If WAIT_CYCLES>0:
  - The accept edge moves the FSM to WAIT with cnt=WAIT_CYCLES.
  - Each WAIT edge decrements cnt.
  - At the WAIT edge where cnt==1, the access is performed, ack is set and the FSM returns to IDLE.
  - ack is high exactly WAIT_CYCLES+1 cycles after the accept cycle.
- req asserted while busy=1 is ignored and not queued. The requester holds req until it sees ack.
- Access is read-first: rdata captures the word's contents before the write. Only lanes with we[i]=1 are updated.
- In the ack cycle busy=0, so a new request may be accepted in that same cycle (back-to-back operation).
- ack is deasserted in every cycle in which no access completes. rdata is unchanged by reads that do not complete.

Optional Feature:
- Macro: DM_RANGE_CHECK_EN.
- Defined: addr[31:ADDR_W+2] != 0 is out of range. For such an access the write is suppressed, rdata is loaded with 0, and err=1 for the ack cycle. Timing is identical to an in-range access.
- Undefined: the address wraps modulo DEPTH_WORDS and err is tied to 0.

Decomposition:
- Package dm_pkg holds:
  - DM_LANES=4 and DM_WORD_W=32.
  - An FSM state enum {DM_IDLE, DM_WAIT}.
  - Lane-mask constants: DM_WE_WORD=4'b1111, DM_WE_HI=4'b1100, DM_WE_LO=4'b0011, DM_WE_NONE=4'b0000.
- One sub-module, dm_byte_ram: a single-port synchronous RAM with per-lane write enables and read-first output, instantiated once. The FSM, counter and range check stay in dm_responder.

Test Plan:
- Reset then read: WAIT_CYCLES=0, read addr 0x0 → ack in cycle 1, rdata=0x00000000, err=0.
- Word write then read: write 0xDEADBEEF to 0x10 with we=1111, then read 0x10 → rdata=0xDEADBEEF.
- Byte lane write: write wdata=0x55555555 with we=0100 to 0x10, then read → rdata=0xDE55BEEF. Halfword write 0xAAAAAAAA with we=0011 → 0xDE55AAAA.
- Wait states and busy: WAIT_CYCLES=3 → ack exactly 4 cycles after accept, busy high for 3 cycles. A second req during busy is ignored. A back-to-back req in the ack cycle is accepted.
- Reset mid-access: WAIT_CYCLES=3, write 0x12345678 to 0x20, assert rst in the second WAIT cycle → no ack, busy=0. A later read of 0x20 returns the prior value 0x00000000.
- Range check (DM_RANGE_CHECK_EN, DEPTH_WORDS=1024): write to 0x00001000 → err=1 with ack, rdata=0, and word 0 unchanged. Without the macro, the same write lands in word 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared constants and types for the data-memory responder.
package dm_pkg;

   localparam int unsigned DM_LANES  = 4;
   localparam int unsigned DM_WORD_W = 32;
   localparam int unsigned DM_CNT_W  = 4;

   typedef enum logic {DM_IDLE, DM_WAIT} dm_state_e;

   localparam logic [DM_LANES-1:0] DM_WE_WORD = 4'b1111;
   localparam logic [DM_LANES-1:0] DM_WE_HI   = 4'b1100;
   localparam logic [DM_LANES-1:0] DM_WE_LO   = 4'b0011;
   localparam logic [DM_LANES-1:0] DM_WE_NONE = 4'b0000;

endpackage

// File: rtl/dm_byte_ram.sv
// Single-port synchronous RAM with per-lane write enables and a read-first registered output.
// Array contents are not reset; only the output register is.
module dm_byte_ram
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [DM_LANES-1:0]  we_i,
   input  logic [ADDR_W-1:0]    idx_i,
   input  logic [DM_WORD_W-1:0] wdata_i,
   output logic [DM_WORD_W-1:0] rdata_o
);

   logic [DM_WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [DM_WORD_W-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int i = 0; i < DM_LANES; i++) begin
            if (we_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Old word is sampled at the same edge as the write, giving read-first behaviour.
   always_comb begin
      rdata_d = rdata_q;
      if (en_i) rdata_d = mem_q[idx_i];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) rdata_q <= '0;
      else       rdata_q <= rdata_d;
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: req/ack handshake with WAIT_CYCLES wait states in front of a byte RAM.
// Define DM_RANGE_CHECK_EN to flag and suppress accesses beyond DEPTH_WORDS instead of wrapping.
module dm_responder
   import dm_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req,
   input  logic [DM_LANES-1:0]  we,
   input  logic [31:0]          addr,
   input  logic [DM_WORD_W-1:0] wdata,
   output logic [DM_WORD_W-1:0] rdata,
   output logic                 ack,
   output logic                 busy,
   output logic                 err
);

   localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
   localparam logic [DM_CNT_W-1:0] WaitInit = DM_CNT_W'(WAIT_CYCLES);

   dm_state_e state_q, state_d;
   logic [DM_CNT_W-1:0]  cnt_q, cnt_d;
   logic                 ack_q, ack_d;
   logic                 oor_q, oor_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [DM_LANES-1:0]  we_q, we_d;
   logic [DM_WORD_W-1:0] wdata_q, wdata_d;
   logic                 lat_oor_q, lat_oor_d;

   logic                 accept, in_oor;
   logic                 acc_en, acc_oor;
   logic [ADDR_W-1:0]    acc_idx;
   logic [DM_LANES-1:0]  acc_we;
   logic [DM_WORD_W-1:0] acc_wdata;
   logic [DM_WORD_W-1:0] ram_rdata;
   logic                 unused_addr;

`ifdef DM_RANGE_CHECK_EN
   assign in_oor      = |addr[31:ADDR_W+2];
   assign unused_addr = ^addr[1:0];
`else
   assign in_oor      = 1'b0;
   assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DM_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         DM_IDLE: begin
            if (accept && (WAIT_CYCLES != 0)) begin
               state_d = DM_WAIT;
               cnt_d   = WaitInit;
            end
         end
         DM_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = DM_IDLE;
         end
         default: state_d = DM_IDLE;
      endcase
   end

   // With no wait states the access uses the live request; otherwise the latched one.
   always_comb begin
      busy   = (state_q == DM_WAIT);
      accept = req && (state_q == DM_IDLE);
      if (WAIT_CYCLES == 0) begin
         acc_en    = accept;
         acc_idx   = addr[ADDR_W+1:2];
         acc_we    = we;
         acc_wdata = wdata;
         acc_oor   = in_oor;
      end else begin
         acc_en    = (state_q == DM_WAIT) && (cnt_q == 4'd1);
         acc_idx   = idx_q;
         acc_we    = we_q;
         acc_wdata = wdata_q;
         acc_oor   = lat_oor_q;
      end
      ack   = ack_q;
      err   = ack_q & oor_q;
      rdata = oor_q ? '0 : ram_rdata;
   end

   always_comb begin
      idx_d     = accept ? addr[ADDR_W+1:2] : idx_q;
      we_d      = accept ? we : we_q;
      wdata_d   = accept ? wdata : wdata_q;
      lat_oor_d = accept ? in_oor : lat_oor_q;
      ack_d     = acc_en;
      oor_d     = acc_en ? acc_oor : oor_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         we_q      <= '0;
         wdata_q   <= '0;
         lat_oor_q <= 1'b0;
         ack_q     <= 1'b0;
         oor_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         we_q      <= we_d;
         wdata_q   <= wdata_d;
         lat_oor_q <= lat_oor_d;
         ack_q     <= ack_d;
         oor_q     <= oor_d;
      end
   end

   // Reset gates the enable so a request seen under reset never writes the array.
   dm_byte_ram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (ADDR_W)
   ) u_ram (
      .clk_i   (clk),
      .rst_i   (rst),
      .en_i    (acc_en & ~rst),
      .we_i    (acc_oor ? DM_WE_NONE : acc_we),
      .idx_i   (acc_idx),
      .wdata_i (acc_wdata),
      .rdata_o (ram_rdata)
   );

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: two instances (0 and 3 wait states) against a transaction-level model.
module tb_dm_responder;

   localparam int NDUT = 2;

   logic        clk = 1'b0;
   logic        rst   [NDUT];
   logic        req   [NDUT];
   logic [3:0]  we    [NDUT];
   logic [31:0] addr  [NDUT];
   logic [31:0] wdata [NDUT];
   logic [31:0] rdata [NDUT];
   logic        ack   [NDUT];
   logic        busy  [NDUT];
   logic        err   [NDUT];

   int checks   = 0;
   int failures = 0;

   dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
      .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0]), .err(err[0])
   );

   dm_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
      .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1]), .err(err[1])
   );

   always #5 clk = ~clk;

   function automatic int wait_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit out_of_range(input logic [31:0] a);
`ifdef DM_RANGE_CHECK_EN
      return (a >> 12) != 32'd0;
`else
      return (a != a);
`endif
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s dut%0d got=%08h want=%08h", name, d, got, want);
      end
   endtask

   // Model: an accept at edge c completes at edge c+W; busy in between; read-first word memory.
   logic [31:0] mmem      [NDUT][1024];
   int          cyc = 0;
   bit          pend      [NDUT];
   int          resp_at   [NDUT];
   logic [9:0]  idx_l     [NDUT];
   logic [3:0]  we_l      [NDUT];
   logic [31:0] wd_l      [NDUT];
   bit          oor_l     [NDUT];
   bit          exp_ack   [NDUT];
   bit          exp_busy  [NDUT];
   bit          exp_err   [NDUT];
   logic [31:0] exp_rdata [NDUT];

   always @(posedge clk) begin
      cyc++;
      for (int d = 0; d < NDUT; d++) begin
         if (rst[d]) begin
            pend[d] = 1'b0; exp_ack[d] = 1'b0; exp_busy[d] = 1'b0;
            exp_err[d] = 1'b0; exp_rdata[d] = 32'h0;
         end else begin
            exp_ack[d] = 1'b0;
            exp_err[d] = 1'b0;
            if (req[d] && !exp_busy[d]) begin
               pend[d]    = 1'b1;
               resp_at[d] = cyc + wait_of(d);
               idx_l[d]   = addr[d][11:2];
               we_l[d]    = we[d];
               wd_l[d]    = wdata[d];
               oor_l[d]   = out_of_range(addr[d]);
            end
            if (pend[d] && cyc == resp_at[d]) begin
               if (oor_l[d]) begin
                  exp_rdata[d] = 32'h0;
                  exp_err[d]   = 1'b1;
               end else begin
                  exp_rdata[d] = mmem[d][idx_l[d]];
                  for (int b = 0; b < 4; b++)
                     if (we_l[d][b]) mmem[d][idx_l[d]][8*b +: 8] = wd_l[d][8*b +: 8];
               end
               exp_ack[d] = 1'b1;
               pend[d]    = 1'b0;
            end
            exp_busy[d] = pend[d];
         end
      end
   end

   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (rst[d]) begin
            check("rst_ack", d, 32'(ack[d]), 32'h0);
            check("rst_busy", d, 32'(busy[d]), 32'h0);
            check("rst_err", d, 32'(err[d]), 32'h0);
            check("rst_rdata", d, rdata[d], 32'h0);
         end else begin
            check("ack", d, 32'(ack[d]), 32'(exp_ack[d]));
            check("busy", d, 32'(busy[d]), 32'(exp_busy[d]));
            check("err", d, 32'(err[d]), 32'(exp_err[d]));
            check("rdata", d, rdata[d], exp_rdata[d]);
         end
      end
   end

   task automatic access(input int d, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] wd, output logic [31:0] rd, output logic e,
                         output int lat);
      @(posedge clk); #1;
      req[d] = 1'b1; addr[d] = a; we[d] = w; wdata[d] = wd;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack[d] && lat < 50);
      check("ack_seen", d, 32'(ack[d]), 32'h1);
      rd = rdata[d];
      e  = err[d];
      req[d] = 1'b0;
   endtask

   logic [31:0] rd;
   logic        e;
   int          lat;
   int          n;

   initial begin
      for (int d = 0; d < NDUT; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 4'h0; addr[d] = 32'h0; wdata[d] = 32'h0;
         for (int i = 0; i < 1024; i++) mmem[d][i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0; rst[1] = 1'b0;

      // Zero wait states: latency, lane merges, read-first.
      access(0, 32'h0, 4'b0000, 32'h0, rd, e, lat);
      check("w0_read0_lat", 0, 32'(lat), 32'd1);
      check("w0_read0_data", 0, rd, 32'h0);
      check("w0_read0_err", 0, 32'(e), 32'h0);
      access(0, 32'h10, 4'b1111, 32'hDEADBEEF, rd, e, lat);
      check("w0_write_old", 0, rd, 32'h0);
      access(0, 32'h10, 4'b0000, 32'h0, rd, e, lat);
      check("w0_word", 0, rd, 32'hDEADBEEF);
      access(0, 32'h10, 4'b0100, 32'h55555555, rd, e, lat);
      check("w0_byte_old", 0, rd, 32'hDEADBEEF);
      access(0, 32'h13, 4'b0000, 32'h0, rd, e, lat);
      check("w0_byte", 0, rd, 32'hDE55BEEF);
      access(0, 32'h10, 4'b0011, 32'hAAAAAAAA, rd, e, lat);
      access(0, 32'h10, 4'b0000, 32'h0, rd, e, lat);
      check("w0_half", 0, rd, 32'hDE55AAAA);

      // One access per cycle.
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         req[0] = 1'b1; we[0] = 4'b1111;
         addr[0] = 32'h100 + 32'(4 * i); wdata[0] = 32'(32'h11111111 * (i + 1));
         @(posedge clk); #1;
         check("stream_wr_ack", 0, 32'(ack[0]), 32'h1);
      end
      for (int i = 0; i < 4; i++) begin
         we[0] = 4'b0000; addr[0] = 32'h100 + 32'(4 * i);
         @(posedge clk); #1;
         check("stream_rd", 0, rdata[0], 32'(32'h11111111 * (i + 1)));
      end
      req[0] = 1'b0;

      // Three wait states.
      access(1, 32'h40, 4'b1111, 32'hA5A5A5A5, rd, e, lat);
      check("w3_lat", 1, 32'(lat), 32'd4);
      access(1, 32'h40, 4'b0000, 32'h0, rd, e, lat);
      check("w3_read", 1, rd, 32'hA5A5A5A5);

      // Payload change while busy is ignored; the request still high in the ack cycle is taken.
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 4'b1111; addr[1] = 32'h80; wdata[1] = 32'h0BADCAFE;
      @(posedge clk); #1;
      check("b2b_busy", 1, 32'(busy[1]), 32'h1);
      addr[1] = 32'h84; wdata[1] = 32'h600DF00D;
      n = 1;
      while (!ack[1] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_lat1", 1, 32'(n), 32'd4);
      check("b2b_ack_busy", 1, 32'(busy[1]), 32'h0);
      @(posedge clk); #1;
      check("b2b_taken", 1, 32'(busy[1]), 32'h1);
      n = 1;
      while (!ack[1] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("b2b_lat2", 1, 32'(n), 32'd4);
      req[1] = 1'b0;
      access(1, 32'h80, 4'b0000, 32'h0, rd, e, lat);
      check("b2b_first", 1, rd, 32'h0BADCAFE);
      access(1, 32'h84, 4'b0000, 32'h0, rd, e, lat);
      check("b2b_second", 1, rd, 32'h600DF00D);

      // Reset in the second wait cycle discards the write.
      @(posedge clk); #1;
      req[1] = 1'b1; we[1] = 4'b1111; addr[1] = 32'h20; wdata[1] = 32'h12345678;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[1] = 1'b1; req[1] = 1'b0;
      #1;
      check("midrst_ack", 1, 32'(ack[1]), 32'h0);
      check("midrst_busy", 1, 32'(busy[1]), 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst[1] = 1'b0;
      access(1, 32'h20, 4'b0000, 32'h0, rd, e, lat);
      check("midrst_mem", 1, rd, 32'h0);

      // Address beyond the array.
      access(0, 32'h00001000, 4'b1111, 32'hCAFEF00D, rd, e, lat);
      check("range_lat", 0, 32'(lat), 32'd1);
      check("range_rdata", 0, rd, 32'h0);
`ifdef DM_RANGE_CHECK_EN
      check("range_err", 0, 32'(e), 32'h1);
      access(0, 32'h0, 4'b0000, 32'h0, rd, e, lat);
      check("range_word0", 0, rd, 32'h0);
`else
      check("range_err", 0, 32'(e), 32'h0);
      access(0, 32'h0, 4'b0000, 32'h0, rd, e, lat);
      check("range_word0", 0, rd, 32'hCAFEF00D);
`endif
      check("range_err_next", 0, 32'(e), 32'h0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
